spi_master: RTL and testbench

//   SPI bus master (mode 0: CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_master_pkg.sv | 15 +
 rtl/spi_master_half_timer.sv | 41 ++++
 rtl/spi_master.sv | 143 ++++++++++++++
 tb/tb_spi_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: FSM state encoding and mode-0 idle levels.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_FINISH
  } state_e;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_master_half_timer.sv
// sclk half-period timer: expire_o pulses halfPeriod cycles after restart_i
// (halfPeriod-1 cycles when short_i accompanies the restart).
module spi_master_half_timer #(
  parameter int halfPeriod = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  input  logic short_i,
  output logic expire_o
);

  localparam int CW = $clog2(halfPeriod + 1);
  localparam logic [CW-1:0] FULL       = CW'(halfPeriod);
  localparam logic [CW-1:0] LOAD_SHORT = (halfPeriod > 1) ? CW'(2) : CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Zero means stopped; the count runs 1..FULL once per restart and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = short_i ? LOAD_SHORT : CW'(1);
    end else if (cnt_q == FULL) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == FULL);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first; done pulses (2*width+1)*halfPeriod cycles after start is accepted.
// start is only honoured while idle; all outputs come straight from registers.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int width      = 8,
  parameter int halfPeriod = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [width-1:0] tx_data_i,
  input  logic             miso_i,
  output logic [width-1:0] rx_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             mosi_o
);

  localparam int BW = $clog2(width + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(width);
  localparam bit NO_LAST_LOW = (halfPeriod == 1);

  state_e           state_q;
  logic [width-1:0] tx_shift_q, rx_shift_q, rx_data_q;
  logic [BW-1:0]    bit_cnt_q;
  logic             cs_q, sclk_q, mosi_q, busy_q, done_q;

  logic expire, restart, restart_short, last_bit;

  assign last_bit = (bit_cnt_q == LAST_BIT);

  // The final low phase is one cycle short: FINISH supplies its last cycle,
  // so cs rises and done appears exactly one half-period after the last fall.
  always_comb begin
    restart       = 1'b0;
    restart_short = 1'b0;
    case (state_q)
      ST_IDLE: restart = start_i;
      ST_LEAD: restart = expire;
      ST_HIGH: begin
        restart       = expire && !(last_bit && NO_LAST_LOW);
        restart_short = last_bit;
      end
      ST_LOW:  restart = expire && !last_bit;
      default: ;
    endcase
  end

  spi_master_half_timer #(
    .halfPeriod(halfPeriod)
  ) u_half_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .restart_i(restart),
    .short_i  (restart_short),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= CS_IDLE;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            tx_shift_q <= tx_data_i;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            cs_q       <= ~CS_IDLE;
            mosi_q     <= tx_data_i[width-1];
            busy_q     <= 1'b1;
            state_q    <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (expire) begin
            sclk_q     <= ~SCLK_IDLE;
            rx_shift_q <= {rx_shift_q[width-2:0], miso_i};
            bit_cnt_q  <= bit_cnt_q + BW'(1);
            state_q    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (expire) begin
            sclk_q <= SCLK_IDLE;
            if (!last_bit) begin
              tx_shift_q <= tx_shift_q << 1;
              mosi_q     <= tx_shift_q[width-2];
              state_q    <= ST_LOW;
            end else if (NO_LAST_LOW) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (expire) begin
            if (last_bit) begin
              state_q <= ST_FINISH;
            end else begin
              sclk_q     <= ~SCLK_IDLE;
              rx_shift_q <= {rx_shift_q[width-2:0], miso_i};
              bit_cnt_q  <= bit_cnt_q + BW'(1);
              state_q    <= ST_HIGH;
            end
          end
        end
        ST_FINISH: begin
          cs_q      <= CS_IDLE;
          sclk_q    <= SCLK_IDLE;
          mosi_q    <= 1'b0;
          rx_data_q <= rx_shift_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cs_o      = cs_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an 8-bit/halfPeriod=2 instance and a 16-bit/halfPeriod=1 instance.
module tb_spi_master;

  localparam int LAT8  = (2 * 8 + 1) * 2;
  localparam int LAT16 = (2 * 16 + 1) * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        start8 = 1'b0;
  logic [7:0]  tx8 = '0;
  logic        miso8;
  logic [7:0]  rx8;
  logic        busy8, done8, cs8, sclk8, mosi8;

  logic        start16 = 1'b0;
  logic [15:0] tx16 = '0;
  logic [15:0] rx16;
  logic        busy16, done16, cs16, sclk16, mosi16;

  // Peripheral: mode-0 shift register, presents its MSB, shifts mosi in on each sclk rise.
  logic        per_sel = 1'b0;
  logic        per_load = 1'b0;
  logic [7:0]  per_load_val = '0;
  logic [7:0]  per_shift = '0;
  logic        per_sclk_prev = 1'b0;
  assign miso8 = per_sel ? per_shift[7] : mosi8;

  always @(negedge clk) begin
    if (per_load) per_shift <= per_load_val;
    else if (sclk8 && !per_sclk_prev) per_shift <= {per_shift[6:0], mosi8};
    per_sclk_prev <= sclk8;
  end

  spi_master #(.width(8), .halfPeriod(2)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start8), .tx_data_i(tx8), .miso_i(miso8),
    .rx_data_o(rx8), .busy_o(busy8), .done_o(done8), .cs_o(cs8), .sclk_o(sclk8), .mosi_o(mosi8)
  );

  spi_master #(.width(16), .halfPeriod(1)) dut16 (
    .clk_i(clk), .reset_i(rst), .start_i(start16), .tx_data_i(tx16), .miso_i(mosi16),
    .rx_data_o(rx16), .busy_o(busy16), .done_o(done16), .cs_o(cs16), .sclk_o(sclk16), .mosi_o(mosi16)
  );

  // Runs one 8-bit frame from a negedge and gathers observations up to the done cycle.
  task automatic run8(input logic [7:0] tx, output logic [7:0] rx, output int lat,
                      output int rises, output int cs_hi, output logic busy_at_done, output bit to);
    int t0;
    logic prev;
    tx8 = tx; start8 = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    rises = 0; cs_hi = 0; to = 1'b1; lat = -1; rx = 'x; busy_at_done = 1'bx; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done8) begin
        lat = cyc - t0; rx = rx8; busy_at_done = busy8; to = 1'b0;
        break;
      end
      if (sclk8 && !prev) rises++;
      prev = sclk8;
      if (cs8) cs_hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (cs8 !== 1'b1 || sclk8 !== 1'b0 || mosi8 !== 1'b0) begin fails++;
      $display("FAIL reset_pins8 cs/sclk/mosi=%b%b%b want 100", cs8, sclk8, mosi8); end
    tests++; if (busy8 !== 1'b0 || done8 !== 1'b0 || rx8 !== 8'h00) begin fails++;
      $display("FAIL reset_status8 busy=%b done=%b rx=%h want 0 0 00", busy8, done8, rx8); end
    tests++; if (cs16 !== 1'b1 || sclk16 !== 1'b0 || busy16 !== 1'b0 || rx16 !== 16'h0) begin fails++;
      $display("FAIL reset16 cs=%b sclk=%b busy=%b rx=%h", cs16, sclk16, busy16, rx16); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (cs8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin fails++;
      $display("FAIL idle_after_reset cs=%b busy=%b done=%b", cs8, busy8, done8); end
  endtask

  task automatic test_loopback();
    logic [7:0] tx, rx;
    int lat, rises, cs_hi;
    logic b;
    bit to;
    per_sel = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tx = (n == 0) ? 8'hA5 : 8'($urandom);
      run8(tx, rx, lat, rises, cs_hi, b, to);
      tests++; if (to) begin fails++; $display("FAIL loop_timeout tx=%h no done", tx); end
      tests++; if (rx !== tx) begin fails++; $display("FAIL loop_rx got %h want %h", rx, tx); end
      tests++; if (lat != LAT8) begin fails++; $display("FAIL loop_latency got %0d want %0d", lat, LAT8); end
      tests++; if (rises != 8) begin fails++; $display("FAIL loop_rises got %0d want 8", rises); end
      tests++; if (cs_hi != 0) begin fails++; $display("FAIL loop_cs_frame cs high %0d cycles want 0", cs_hi); end
      tests++; if (b !== 1'b0 || cs8 !== 1'b1) begin fails++;
        $display("FAIL loop_done_cycle busy=%b cs=%b want 0 1", b, cs8); end
      @(negedge clk);
      tests++; if (done8 !== 1'b0 || rx8 !== tx) begin fails++;
        $display("FAIL loop_after_done done=%b rx=%h want 0 %h", done8, rx8, tx); end
    end
  endtask

  task automatic test_peripheral();
    logic [7:0] tx, pre, rx;
    int lat, rises, cs_hi;
    logic b;
    bit to;
    per_sel = 1'b1;
    for (int n = 0; n < 4; n++) begin
      pre = (n == 0) ? 8'h3C : 8'($urandom);
      tx  = (n == 0) ? 8'hC3 : 8'($urandom);
      per_load_val = pre; per_load = 1'b1;
      @(negedge clk);
      @(posedge clk);
      per_load = 1'b0;
      @(negedge clk);
      run8(tx, rx, lat, rises, cs_hi, b, to);
      tests++; if (to) begin fails++; $display("FAIL per_timeout tx=%h", tx); end
      tests++; if (rx !== pre) begin fails++; $display("FAIL per_master_rx got %h want %h", rx, pre); end
      tests++; if (per_shift !== tx) begin fails++; $display("FAIL per_parallel_out got %h want %h", per_shift, tx); end
      @(negedge clk);
    end
    per_sel = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [7:0] tx, rx;
    int t0, lat, dones, cs_low;
    bit seen;
    tx = 8'($urandom_range(0, 254));
    tx8 = tx; start8 = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; seen = 1'b0; lat = -1; rx = 'x;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done8) begin
        seen = 1'b1; lat = cyc - t0; rx = rx8;
      end else begin
        start8 = (cyc == t0 + 4) || (cyc == t0 + 19);
        if (start8) tx8 = 8'hFF;
        @(negedge clk);
      end
    end
    start8 = 1'b0;
    tests++; if (!seen) begin fails++; $display("FAIL ign_timeout no done"); end
    tests++; if (rx !== tx) begin fails++; $display("FAIL ign_rx got %h want %h", rx, tx); end
    tests++; if (lat != LAT8) begin fails++; $display("FAIL ign_latency got %0d want %0d", lat, LAT8); end
    dones = 0; cs_low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done8) dones++;
      if (!cs8) cs_low++;
    end
    tests++; if (dones != 0 || cs_low != 0) begin fails++;
      $display("FAIL ign_no_second extra done=%0d cs low=%0d want 0 0", dones, cs_low); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] tx, rx;
    int t0, lat, rises, cs_hi, dones;
    logic b;
    bit to;
    run8(8'h5A, rx, lat, rises, cs_hi, b, to);
    tests++; if (rx !== 8'h5A) begin fails++; $display("FAIL rst_pre_rx got %h want 5a", rx); end
    @(negedge clk);
    tx8 = 8'($urandom); start8 = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc < t0 + 14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (cs8 !== 1'b1 || sclk8 !== 1'b0 || mosi8 !== 1'b0 || busy8 !== 1'b0 || rx8 !== 8'h00) begin fails++;
      $display("FAIL rst_mid cs=%b sclk=%b mosi=%b busy=%b rx=%h want 1 0 0 0 00", cs8, sclk8, mosi8, busy8, rx8); end
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done8 || !cs8) dones++;
    end
    tests++; if (dones != 0) begin fails++; $display("FAIL rst_no_done activity %0d cycles want 0", dones); end
    tx = 8'($urandom);
    run8(tx, rx, lat, rises, cs_hi, b, to);
    tests++; if (rx !== tx || lat != LAT8 || rises != 8) begin fails++;
      $display("FAIL rst_restart rx=%h lat=%0d rises=%0d want %h %0d 8", rx, lat, rises, tx, LAT8); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, lat;
    logic [7:0] rx;
    bit seen;
    tx8 = 8'h01; start8 = 1'b1; t0 = cyc + 1;
    @(negedge clk);
    tx8 = 8'h80;
    seen = 1'b0; lat = -1; rx = 'x;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done8) begin seen = 1'b1; lat = cyc - t0; rx = rx8; end
      else @(negedge clk);
    end
    tests++; if (!seen || rx !== 8'h01 || lat != LAT8) begin fails++;
      $display("FAIL b2b_first seen=%b rx=%h lat=%0d want 1 01 %0d", seen, rx, lat, LAT8); end
    tests++; if (cs8 !== 1'b1) begin fails++; $display("FAIL b2b_gap_high cs=%b want 1", cs8); end
    @(negedge clk);
    tests++; if (cs8 !== 1'b0 || busy8 !== 1'b1) begin fails++;
      $display("FAIL b2b_gap_len cs=%b busy=%b want 0 1", cs8, busy8); end
    t0 = cyc; start8 = 1'b0;
    seen = 1'b0; lat = -1; rx = 'x;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done8) begin seen = 1'b1; lat = cyc - t0; rx = rx8; end
      else @(negedge clk);
    end
    tests++; if (!seen || rx !== 8'h80 || lat != LAT8) begin fails++;
      $display("FAIL b2b_second seen=%b rx=%h lat=%0d want 1 80 %0d", seen, rx, lat, LAT8); end
    @(negedge clk);
  endtask

  task automatic test_wide();
    logic [15:0] tx, rx;
    int t0, lat, rises, gap_bad, last_rise;
    logic prev;
    bit seen;
    for (int n = 0; n < 3; n++) begin
      tx = (n == 0) ? 16'hBEEF : 16'($urandom);
      tx16 = tx; start16 = 1'b1; t0 = cyc + 1;
      @(negedge clk);
      start16 = 1'b0;
      seen = 1'b0; lat = -1; rx = 'x; rises = 0; gap_bad = 0; last_rise = -1; prev = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (done16) begin
          seen = 1'b1; lat = cyc - t0; rx = rx16;
        end else begin
          if (sclk16 && !prev) begin
            if (last_rise >= 0 && cyc - last_rise != 2) gap_bad++;
            last_rise = cyc; rises++;
          end
          prev = sclk16;
          @(negedge clk);
        end
      end
      tests++; if (!seen) begin fails++; $display("FAIL wide_timeout tx=%h", tx); end
      tests++; if (rx !== tx) begin fails++; $display("FAIL wide_rx got %h want %h", rx, tx); end
      tests++; if (lat != LAT16) begin fails++; $display("FAIL wide_latency got %0d want %0d", lat, LAT16); end
      tests++; if (rises != 16 || gap_bad != 0) begin fails++;
        $display("FAIL wide_sclk rises=%0d bad periods=%0d want 16 0", rises, gap_bad); end
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_peripheral();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
